// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor: diff = a - b - bin (mod 2^WIDTH).
//   It uses one full-subtractor cell and a borrow flop, and works LSB first
//   at one bit per clock. A start/busy/done handshake lets operations be
//   issued back to back.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start; a/b/bin are captured on the accepting edge
//   SHIFT  | one result bit per edge; busy=1
//   DONE   | one-cycle done pulse; diff/bout/ovf were updated on entry
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request a subtraction (honoured only in IDLE)
//   a      in   minuend     [WIDTH]
//   b      in   subtrahend  [WIDTH]
//   bin    in   borrow-in
//   busy   out  operation in progress
//   done   out  single-cycle completion pulse
//   diff   out  result      [WIDTH], held until the next completion
//   bout   out  final borrow (unsigned a < b + bin)
//   ovf    out  signed overflow

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_b_q, sign_b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   logic             a0, b0, d_bit, br_nxt;
   logic [WIDTH-1:0] res_shift;

   always_comb begin
      a0        = a_sh_q[0];
      b0        = b_sh_q[0];
      d_bit     = a0 ^ b0 ^ br_q;
      br_nxt    = (~a0 & b0) | (~(a0 ^ b0) & br_q);
      res_shift = {d_bit, res_q[WIDTH-1:1]};

      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      br_d     = br_q;
      cnt_d    = cnt_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               br_d     = bin;
               res_d    = '0;
               cnt_d    = '0;
               sign_a_d = a[WIDTH-1];
               sign_b_d = b[WIDTH-1];
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = res_shift;
            br_d   = br_nxt;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               // The final bit is the result MSB, so it decides the overflow test.
               diff_d  = res_shift;
               bout_d  = br_nxt;
               ovf_d   = (sign_a_q != sign_b_q) && (d_bit != sign_a_q);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy = (state_q == S_SHIFT);
   assign done = (state_q == S_DONE);
   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst, start, bin;
   logic [WIDTH-1:0] a, b;
   logic             busy, done, bout, ovf;
   logic [WIDTH-1:0] diff;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Reference model. It tracks cycles elapsed since acceptance and computes
   // the result arithmetically when the operation is accepted.
   int               m_phase = 0;   // 0 idle, 1..WIDTH shifting, WIDTH+1 done
   logic [WIDTH-1:0] m_diff = '0, m_pend_diff;
   logic             m_bout = 1'b0, m_ovf = 1'b0, m_pend_bout, m_pend_ovf;
   logic             chk_en = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_diff  = '0;
         m_bout  = 1'b0;
         m_ovf   = 1'b0;
         chk_en  = 1'b1;
      end else if (m_phase == 0) begin
         if (start) begin
            int ua, ub;
            ua = int'(a);
            ub = int'(b);
            m_pend_diff = WIDTH'(ua - ub - int'(bin));
            m_pend_bout = (ua < ub + int'(bin));
            m_pend_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (m_pend_diff[WIDTH-1] != a[WIDTH-1]);
            m_phase     = 1;
         end
      end else if (m_phase <= WIDTH) begin
         m_phase = m_phase + 1;
         if (m_phase == WIDTH + 1) begin
            m_diff = m_pend_diff;
            m_bout = m_pend_bout;
            m_ovf  = m_pend_ovf;
         end
      end else begin
         m_phase = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_busy, exp_done;
         exp_busy = (m_phase >= 1) && (m_phase <= WIDTH);
         exp_done = (m_phase == WIDTH + 1);
         checks++;
         if (busy !== exp_busy || done !== exp_done || diff !== m_diff ||
             bout !== m_bout || ovf !== m_ovf) begin
            errors++;
            $display("FAIL cycle_model t=%0t got busy=%b done=%b diff=%h bout=%b ovf=%b expected busy=%b done=%b diff=%h bout=%b ovf=%b",
                     $time, busy, done, diff, bout, ovf, exp_busy, exp_done, m_diff, m_bout, m_ovf);
         end
      end
   end

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // One operation: start is driven for one cycle, then the inputs are
   // scrambled, and the task waits for done and checks latency and busy length.
   task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi,
                         output logic [WIDTH-1:0] d, output logic bo, output logic ov);
      int n, nbusy;
      @(negedge clk);
      a = av; b = bv; bin = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
      n = 0; nbusy = 0;
      while (!done && n < 40) begin
         if (busy) nbusy++;
         @(negedge clk);
         n++;
      end
      check("latency", n, WIDTH);
      check("busy_cycles", nbusy, WIDTH);
      d = diff; bo = bout; ov = ovf;
      @(negedge clk);
   endtask

   task automatic directed(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic bi, input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
      logic [WIDTH-1:0] d;
      logic bo, ov;
      run_op(av, bv, bi, d, bo, ov);
      check({name, "_diff"}, int'(d), int'(ed));
      check({name, "_bout"}, int'(bo), int'(eb));
      check({name, "_ovf"}, int'(ov), int'(eo));
   endtask

   initial begin
      logic [WIDTH-1:0] d, s, av, bv;
      logic bo, ov;
      int ndone;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_diff", int'(diff), 0);
      check("reset_flags", int'({bout, ovf}), 0);
      rst = 1'b0;

      directed("t1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      directed("t2a", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
      directed("t2b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      directed("t3a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      directed("t3b", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
      directed("equal", 8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);

      // A start while busy is ignored: one done pulse, first result only.
      @(negedge clk);
      a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0; a = 8'h33; b = 8'h44;
      repeat (2) @(negedge clk);
      a = 8'hAA; b = 8'h55; start = 1'b1;
      @(negedge clk); start = 1'b0; a = 8'hC3; b = 8'h3C;
      ndone = 0;
      for (int i = 0; i < 16; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("busy_start_done_count", ndone, 1);
      check("busy_start_diff", int'(diff), 8'h0F);
      check("busy_start_idle", int'(busy), 0);

      // Reset mid-operation aborts without a done pulse.
      @(negedge clk);
      a = 8'hF0; b = 8'h0F; start = 1'b1;
      @(negedge clk); start = 1'b0;
      ndone = 0;
      repeat (3) begin
         if (done) ndone++;
         @(negedge clk);
      end
      rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("abort_no_done", ndone, 0);
      check("abort_outputs", int'({busy, done, diff, bout, ovf}), 0);
      directed("after_abort", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

      // Adder cross-check: (A + B) - B must return A.
      for (int i = 0; i < 12; i++) begin
         av = WIDTH'($urandom);
         bv = WIDTH'($urandom);
         s  = av + bv;
         run_op(s, bv, 1'b0, d, bo, ov);
         check("adder_roundtrip", int'(d), int'(av));
      end

      // Random operations; the per-cycle model comparison covers the results.
      for (int i = 0; i < 60; i++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), d, bo, ov);
         if (($urandom % 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached at t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor, the inverse operation of the team's 8-bit ripple-carry adder. It computes A - B - Bin with a single full-subtractor cell and a borrow flip-flop, one bit per clock, LSB first. The start/busy/done handshake lets a controller or bench issue operations back to back. The result uses the same 8-bit operand width as the adder path, so the two blocks can be cross-checked (A + B then minus B).

Parameters:
WIDTH, 8, operand and result width in bits (valid for WIDTH >= 2).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new subtraction; accepted only in IDLE.
a  input  WIDTH  minuend; sampled on the accepting edge only.
b  input  WIDTH  subtrahend; sampled on the accepting edge only.
bin  input  1  borrow-in; sampled on the accepting edge only.
busy  output  1  high while an operation is in progress (SHIFT state).
done  output  1  single-cycle pulse; result outputs are valid from this cycle.
diff  output  WIDTH  result A - B - Bin, modulo 2^WIDTH.
bout  output  1  final borrow; 1 when unsigned A < B + Bin.
ovf  output  1  signed overflow flag.

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst.
- Reset (rst=1 at a rising edge):
  - state goes to IDLE.
  - busy, done, diff, bout and ovf all go to 0.
  - Internal shift registers, borrow flip-flop and bit counter are cleared.
  - rst takes priority over every other input.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - On an edge with start=1: load a and b into shift registers, load bin into the borrow flip-flop, clear the counter, capture a[WIDTH-1] and b[WIDTH-1] into sign registers, then go to SHIFT.
- SHIFT (busy=1), one bit per edge, using a0/b0 = current LSBs of the shift registers and br = the borrow flip-flop:
  - d = a0 ^ b0 ^ br.
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the MSB of the result register; both operand registers shift right.
  - Counter increments; after the WIDTH-th bit edge, go to DONE.
- DONE entry (on the final SHIFT edge, registered):
  - diff = result register; bout = br'.
  - ovf = (signA != signB) && (diff[WIDTH-1] != signA).
  - done=1 and busy=0 for exactly one cycle; the next edge returns to IDLE.
- Latency: start is sampled at edge E0; done is high during the cycle after edge E(WIDTH), i.e. WIDTH+1 edges from acceptance. Minimum issue interval is WIDTH+2 cycles.
- diff, bout and ovf hold their values until the next DONE entry or a reset. They do not change during SHIFT, so the previous result stays readable.
- start is ignored while in SHIFT or DONE: no queuing, and the operation in flight is unaffected.
- Changes on a, b or bin after the accepting edge have no effect.
- Reset mid-SHIFT aborts the operation: done is not pulsed and the outputs are zeroed.
- Reset and start asserted on the same edge: reset wins and the state stays IDLE.
- Edge operands need no special casing: a=b gives diff=0 (with bin=0); all-zero operands with bin=1 give diff = all ones with bout=1.

Test Plan:
1. After reset, with a=8'h05, b=8'h03, bin=0, pulse start → done exactly 9 edges later; diff=8'h02, bout=0, ovf=0; busy high for 8 cycles.
2. a=8'h03, b=8'h05, bin=0 → diff=8'hFE, bout=1, ovf=0. Then a=8'h00, b=8'h00, bin=1 → diff=8'hFF, bout=1, ovf=0.
3. Signed overflow: a=8'h80, b=8'h01 → diff=8'h7F, bout=0, ovf=1. Then a=8'h7F, b=8'hFF → diff=8'h80, bout=1, ovf=1.
4. Start while busy: start a=8'h10, b=8'h01; 3 cycles later, pulse start with a=8'hAA, b=8'h55 and change the a/b inputs → diff=8'h0F with a single done pulse, and no second operation begins.
5. Reset mid-operation: assert rst 4 cycles after start → no done pulse, all outputs 0, state IDLE; a following start (a=8'h09, b=8'h04) returns diff=8'h05 with normal latency.
6. Cross-check against the adder: for each test vector, drive the adder with A and B to get S, then run serial_subtractor with a=S, b=B, bin=0 → diff equals the original A.
